// File: rtl/ir_frame_decoder.sv
// ir_frame_decoder
// Serial IR frame decoder for the game controller input path.
// Frame: start bit (0), DATA_BITS data bits LSB first, optional even parity
// bit, stop bit (1). The raw line is double-flopped before any decision.
// Accepted codes above MAX_CODE are rejected with a frame_err pulse.
// Optional feature macro: IRDA_PARITY_EN (adds the PARITY state).
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | line idle, waiting for irda_s to fall
//   START     | half a bit period into the start bit, glitch check
//   DATA      | sampling data bits at mid-bit, shifting in LSB first
//   PARITY    | sampling parity bit (only with IRDA_PARITY_EN)
//   STOP      | sampling stop bit, range check, publish code
//   WAIT_IDLE | framing error seen, wait for the line to return high

module ir_frame_decoder #(
  parameter int DATA_BITS = 3,
  parameter int BIT_TICKS = 32,
  parameter int MAX_CODE  = 6,
  parameter int CNT_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 irda,
  output logic [DATA_BITS-1:0] code,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int TICK_W = $clog2(BIT_TICKS);
  localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0]    BIT_TC   = TICK_W'(BIT_TICKS - 1);
  localparam logic [TICK_W-1:0]    HALF_TC  = TICK_W'(BIT_TICKS / 2 - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [DATA_BITS-1:0] MAX_C    = DATA_BITS'(MAX_CODE);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
`ifdef IRDA_PARITY_EN
    PARITY    = 3'd5,
`endif
    WAIT_IDLE = 3'd4
  } state_t;

  state_t               state;
  logic                 irda_m;
  logic                 irda_s;
  logic [TICK_W-1:0]    tick;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS:0]   shift_cat;

  // Right shift with the new sample entering at the MSB; works for DATA_BITS=1.
  assign shift_cat = {irda_s, shift};

  // busy is decoded straight from the state register.
  assign busy = (state != IDLE);

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irda_m <= 1'b1;
      irda_s <= 1'b1;
    end else begin
      irda_m <= irda;
      irda_s <= irda_m;
    end
  end

  // Frame FSM with registered code/valid/frame_err/frame_cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick      <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      code      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          tick    <= '0;
          bit_idx <= '0;
          if (!irda_s) state <= START;
        end
        START: begin
          if (tick == HALF_TC) begin
            tick <= '0;
            if (irda_s) begin
              // Line went back high before mid-start: treat as a glitch.
              state <= IDLE;
            end else begin
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DATA: begin
          if (tick == BIT_TC) begin
            tick  <= '0;
            shift <= shift_cat[DATA_BITS:1];
            if (bit_idx == LAST_IDX) begin
`ifdef IRDA_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
`ifdef IRDA_PARITY_EN
        PARITY: begin
          if (tick == BIT_TC) begin
            tick <= '0;
            if (irda_s == ^shift) begin
              state <= STOP;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick == BIT_TC) begin
            tick <= '0;
            if (!irda_s) begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end else if (shift > MAX_C) begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end else begin
              code      <= shift;
              valid     <= 1'b1;
              frame_cnt <= frame_cnt + 1'b1;
              state     <= IDLE;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        WAIT_IDLE: begin
          tick <= '0;
          if (irda_s) state <= IDLE;
        end
        default: begin
          tick  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_frame_decoder.sv
// tb_ir_frame_decoder
// Directed bench for ir_frame_decoder with DATA_BITS=3, BIT_TICKS=8,
// MAX_CODE=6, CNT_W=2. Define IRDA_PARITY_EN for both files to cover parity.

module tb_ir_frame_decoder;

  localparam int DB = 3;
  localparam int BT = 8;
  localparam int MC = 6;
  localparam int CW = 2;
`ifdef IRDA_PARITY_EN
  localparam int LAT = 46;
`else
  localparam int LAT = 38;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          irda = 1'b1;
  logic [DB-1:0] code;
  logic          valid;
  logic          frame_err;
  logic          busy;
  logic [CW-1:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int fall_cyc = 0;
  int valid_cyc = -1;
  int v0, e0, bc;

  logic [DB-1:0] b2b_code [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
  logic [CW-1:0] b2b_cnt  [5] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

  ir_frame_decoder #(
    .DATA_BITS(DB),
    .BIT_TICKS(BT),
    .MAX_CODE (MC),
    .CNT_W    (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irda     (irda),
    .code     (code),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse bookkeeping, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      valid_cyc = cyc;
    end
    if (frame_err) err_cnt++;
    if (valid || frame_err) check("excl", {31'b0, valid & frame_err}, 32'd0);
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full frame; d[0] goes first. The parity bit only occupies the line
  // when the parity state is built in.
  task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stp);
    irda = 1'b0;
    fall_cyc = cyc + 1;
    clks(BT);
    for (int i = 0; i < DB; i++) begin
      irda = d[i];
      clks(BT);
    end
    irda = par;
`ifdef IRDA_PARITY_EN
    clks(BT);
`endif
    irda = stp;
    clks(BT);
  endtask

  initial begin
    rst = 1'b1;
    irda = 1'b1;
    clks(3);
    check("rst_out", {24'b0, code, valid, frame_err, busy, frame_cnt}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      clks(1);
      check("idle", {24'b0, code, valid, frame_err, busy, frame_cnt}, 32'd0);
    end

    // Bits 1,0,1 LSB first -> 3'b101
    send_frame(3'b101, 1'b0, 1'b1);
    check("f1_code", 32'(code), 32'd5);
    check("f1_cnt", 32'(frame_cnt), 32'd1);
    check("f1_valid_n", 32'(valid_cnt), 32'd1);
    check("f1_err_n", 32'(err_cnt), 32'd0);
    check("f1_latency", 32'(valid_cyc - fall_cyc), 32'(LAT));
    clks(4);

    // Two-clock glitch
    v0 = valid_cnt;
    e0 = err_cnt;
    bc = 0;
    irda = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 2) irda = 1'b1;
      clks(1);
      if (busy) bc++;
    end
    check("glitch_busy_clks", 32'(bc), 32'd4);
    check("glitch_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_err", 32'(err_cnt - e0), 32'd0);
    check("glitch_idle", {31'b0, busy}, 32'd0);

    // Bad stop bit, data 0,1,0, line held low afterwards
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(3'b010, 1'b1, 1'b0);
    clks(20);
    check("stop0_busy_low", {31'b0, busy}, 32'd1);
    check("stop0_err", 32'(err_cnt - e0), 32'd1);
    check("stop0_valid", 32'(valid_cnt - v0), 32'd0);
    check("stop0_code", 32'(code), 32'd5);
    irda = 1'b1;
    clks(4);
    check("stop0_release", {31'b0, busy}, 32'd0);

    // Out-of-range code 7
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(3'b111, 1'b1, 1'b1);
    clks(2);
    check("c7_err", 32'(err_cnt - e0), 32'd1);
    check("c7_valid", 32'(valid_cnt - v0), 32'd0);
    check("c7_code", 32'(code), 32'd5);
    check("c7_cnt", 32'(frame_cnt), 32'd1);
    check("c7_idle", {31'b0, busy}, 32'd0);

    // Five back-to-back frames, counter wraps 3 -> 0
    v0 = valid_cnt;
    for (int i = 0; i < 5; i++) begin
      send_frame(b2b_code[i], ^b2b_code[i], 1'b1);
      check("b2b_code", 32'(code), 32'(b2b_code[i]));
      check("b2b_cnt", 32'(frame_cnt), 32'(b2b_cnt[i]));
    end
    check("b2b_valid_n", 32'(valid_cnt - v0), 32'd5);
    clks(4);

`ifdef IRDA_PARITY_EN
    // Data 1,1,0 with correct parity 0, then with wrong parity 1
    e0 = err_cnt;
    send_frame(3'b011, 1'b0, 1'b1);
    check("par_ok_code", 32'(code), 32'd3);
    check("par_ok_cnt", 32'(frame_cnt), 32'd3);
    check("par_ok_err", 32'(err_cnt - e0), 32'd0);
    v0 = valid_cnt;
    send_frame(3'b011, 1'b1, 1'b1);
    clks(4);
    check("par_bad_err", 32'(err_cnt - e0), 32'd1);
    check("par_bad_valid", 32'(valid_cnt - v0), 32'd0);
    check("par_bad_idle", {31'b0, busy}, 32'd0);
`endif

    // Reset in the middle of the data bits
    irda = 1'b0;
    clks(15);
    check("mid_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out", {24'b0, code, valid, frame_err, busy, frame_cnt}, 32'd0);
    v0 = valid_cnt;
    e0 = err_cnt;
    irda = 1'b1;
    clks(2);
    rst = 1'b0;
    clks(40);
    check("post_rst_idle", {31'b0, busy}, 32'd0);
    check("post_rst_valid", 32'(valid_cnt - v0), 32'd0);
    check("post_rst_err", 32'(err_cnt - e0), 32'd0);

    // Largest legal code after reset
    send_frame(3'b110, 1'b0, 1'b1);
    check("max_code", 32'(code), 32'd6);
    check("max_cnt", 32'(frame_cnt), 32'd1);
    clks(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
